// File: rtl/regfile_dump_pkg.sv
// regfile_dump shared constants and FSM state encoding.
// Optional checksum beat is enabled by REGDUMP_CHECKSUM_EN.
package regfile_dump_pkg;

    localparam int WIDTH   = 32;
    localparam int R_WIDTH = 5;
    localparam int REGSIZE = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HALT = 3'd1,
        READ = 3'd2,
        SEND = 3'd3,
        CSUM = 3'd4,
        FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// regfile_dump output stream: valid/ready with data, index, last.
// Master drives the beat, slave returns ready.
interface regfile_dump_if
    import regfile_dump_pkg::*;
#(
    parameter int W  = regfile_dump_pkg::WIDTH,
    parameter int RW = regfile_dump_pkg::R_WIDTH
) ();

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [RW-1:0] out_idx;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Register file debug dump: stall CPU, walk index range, stream words.
// REGDUMP_CHECKSUM_EN appends an XOR checksum beat with all-ones index.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int WIDTH   = regfile_dump_pkg::WIDTH,
    parameter int R_WIDTH = regfile_dump_pkg::R_WIDTH,
    parameter int REGSIZE = regfile_dump_pkg::REGSIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [R_WIDTH-1:0] first_reg,
    input  logic [R_WIDTH-1:0] last_reg,
    output logic               stall_req,
    input  logic               stall_ack,
    output logic [R_WIDTH-1:0] rd_reg,
    input  logic [WIDTH-1:0]   rd_data,
    regfile_dump_if.master     out,
    output logic               busy,
    output logic               done,
    output logic               range_err
);

    localparam logic [R_WIDTH:0] MAX_IDX = (R_WIDTH+1)'(REGSIZE - 1);

    state_t             state;
    state_t             state_n;
    logic [R_WIDTH-1:0] idx;
    logic [R_WIDTH-1:0] lo;
    logic [R_WIDTH-1:0] hi;
    logic               bad;
    logic               hs;
    logic               at_last;
`ifdef REGDUMP_CHECKSUM_EN
    logic [WIDTH-1:0]   acc;
`endif

    assign bad = (first_reg > last_reg)
              || ({1'b0, last_reg} > MAX_IDX);
    assign hs      = out.out_valid && out.out_ready;
    assign at_last = (idx == hi);

    assign busy      = (state != IDLE);
    assign stall_req = (state != IDLE);
    assign rd_reg    = idx;
    assign out.out_valid = (state == SEND) || (state == CSUM);
`ifdef REGDUMP_CHECKSUM_EN
    assign out.out_last = (state == CSUM);
`else
    assign out.out_last = (state == SEND) && at_last;
`endif

    // State register; reset aborts any dump in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start && !bad) state_n = HALT;
            HALT: if (stall_ack) state_n = READ;
            READ: state_n = SEND;
            SEND: begin
                if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
                    state_n = at_last ? CSUM : READ;
`else
                    state_n = at_last ? FIN : READ;
`endif
                end
            end
            CSUM: if (hs) state_n = FIN;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Range latch, index walk, beat capture and done/error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            lo           <= '0;
            hi           <= '0;
            out.out_data <= '0;
            out.out_idx  <= '0;
            done         <= 1'b0;
            range_err    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc          <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lo        <= first_reg;
                        hi        <= last_reg;
                        range_err <= bad;
                        done      <= bad;
`ifdef REGDUMP_CHECKSUM_EN
                        acc       <= '0;
`endif
                    end
                end
                HALT: if (stall_ack) idx <= lo;
                READ: begin
                    out.out_data <= rd_data;
                    out.out_idx  <= idx;
`ifdef REGDUMP_CHECKSUM_EN
                    acc          <= acc ^ rd_data;
`endif
                end
                SEND: begin
                    if (hs) begin
                        if (at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
                            out.out_data <= acc;
                            out.out_idx  <= '1;
`else
                            done <= 1'b1;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                CSUM: if (hs) done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table vectors, random ranges,
// backpressure, mid-dump reset, optional checksum beat.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic        stall_req;
    logic        stall_ack = 1'b0;
    logic [4:0]  rd_reg;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [31:0] regs [32];

    regfile_dump_if bus ();

    regfile_dump dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .stall_req (stall_req),
        .stall_ack (stall_ack),
        .rd_reg    (rd_reg),
        .rd_data   (rd_data),
        .out       (bus),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    assign rd_data = regs[rd_reg];

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } beat_t;

    typedef struct {
        int f;
        int l;
        int ack_delay;
        bit rnd;
        bit exp_err;
    } vec_t;

    beat_t expq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected stream: one word per index in range, then optional checksum.
    task automatic build_model(input int f, input int l, output bit err);
        logic [31:0] x;
        bit lb;
        x = '0;
        expq.delete();
        err = (f > l) || (l > REGSIZE - 1);
        if (!err) begin
            for (int i = f; i <= l; i++) begin
`ifdef REGDUMP_CHECKSUM_EN
                lb = 1'b0;
`else
                lb = (i == l);
`endif
                expq.push_back('{regs[i], 5'(i), lb});
                x ^= regs[i];
            end
`ifdef REGDUMP_CHECKSUM_EN
            expq.push_back('{x, 5'h1f, 1'b1});
`endif
        end
    endtask

    task automatic run_dump(input int f, input int l, input int ack_delay,
                            input bit rnd, input bit exp_err,
                            input string tag);
        bit    err;
        bit    held;
        bit    finished;
        bit    stall_seen;
        int    stall_cnt;
        int    beats;
        int    nexp;
        int    dones;
        int    hs_cyc;
        int    done_cyc;
        int    valid_cnt;
        int    first_valid;
        beat_t hb;
        beat_t e;
        build_model(f, l, err);
        nexp = expq.size();
        held = 0; finished = 0; stall_seen = 0;
        stall_cnt = 0; beats = 0; dones = 0;
        hs_cyc = -1; done_cyc = -1; valid_cnt = 0; first_valid = -1;
        stall_ack = 1'b0;
        @(negedge clk);
        start = 1'b1;
        first_reg = 5'(f);
        last_reg = 5'(l);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_req) stall_cnt++;
            else           stall_cnt = 0;
            stall_ack = stall_req && (stall_cnt > ack_delay);
            #1;
            if (stall_req) stall_seen = 1;
            if (held) begin
                check({tag, " hold_valid"}, bus.out_valid, 1);
                check({tag, " hold_data"}, bus.out_data, hb.data);
                check({tag, " hold_idx"}, bus.out_idx, hb.idx);
                check({tag, " hold_last"}, bus.out_last, hb.last);
            end
            held = 0;
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                if (bus.out_ready) begin
                    beats++;
                    hs_cyc = cyc;
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check({tag, " data"}, bus.out_data, e.data);
                        check({tag, " idx"}, bus.out_idx, e.idx);
                        check({tag, " last"}, bus.out_last, e.last);
                    end else begin
                        check({tag, " extra_beat"}, beats, nexp);
                    end
                end else begin
                    held = 1;
                    hb = '{bus.out_data, bus.out_idx, bus.out_last};
                end
            end
            if (dones > 0 && cyc == done_cyc + 1) begin
                check({tag, " busy_after_done"}, busy, 0);
                check({tag, " stall_after_done"}, stall_req, 0);
                check({tag, " done_width"}, done, 0);
                finished = 1;
                break;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        stall_ack = 1'b0;
        check({tag, " finished"}, finished, 1);
        check({tag, " beats"}, beats, nexp);
        check({tag, " range_err"}, range_err, exp_err);
        if (exp_err) begin
            check({tag, " err_no_stall"}, stall_seen, 0);
            check({tag, " err_no_valid"}, valid_cnt, 0);
            check({tag, " err_done_cyc"}, done_cyc, 1);
        end else begin
            check({tag, " latency"}, first_valid, ack_delay + 3);
            check({tag, " done_cyc"}, done_cyc, hs_cyc + 1);
        end
    endtask

    vec_t vecs [6];
    bit   found;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        bus.out_ready = 1'b0;
        #1;
        check("rst stall_req", stall_req, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_data", bus.out_data, 0);
        check("rst out_idx", bus.out_idx, 0);
        check("rst out_last", bus.out_last, 0);
        check("rst rd_reg", rd_reg, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst range_err", range_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{0, 31, 3, 1'b0, 1'b0};
        vecs[1] = '{5, 5, 0, 1'b0, 1'b0};
        vecs[2] = '{9, 4, 1, 1'b0, 1'b1};
        vecs[3] = '{2, 6, 2, 1'b1, 1'b0};
        vecs[4] = '{31, 31, 1, 1'b1, 1'b0};
        vecs[5] = '{0, 1, 0, 1'b1, 1'b0};
        for (int v = 0; v < 6; v++) begin
            run_dump(vecs[v].f, vecs[v].l, vecs[v].ack_delay,
                     vecs[v].rnd, vecs[v].exp_err,
                     $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 8; r++) begin
            int f;
            int l;
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            run_dump(f, l, $urandom_range(0, 4), 1'b1, (f > l),
                     $sformatf("rnd%0d", r));
        end

        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + i * 3;
        found = 0;
        @(negedge clk);
        start = 1'b1;
        first_reg = 5'd0;
        last_reg = 5'd31;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            stall_ack = stall_req;
            #1;
            if (bus.out_valid && bus.out_idx == 5'd12) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("midrst reached_idx12", found, 1);
        rst_n = 1'b0;
        #1;
        check("midrst stall_req", stall_req, 0);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst out_data", bus.out_data, 0);
        check("midrst out_idx", bus.out_idx, 0);
        check("midrst out_last", bus.out_last, 0);
        check("midrst rd_reg", rd_reg, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        stall_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(0, 31, 1, 1'b0, 1'b0, "post_rst");

`ifdef REGDUMP_CHECKSUM_EN
        regs[0] = 32'd1;
        regs[1] = 32'd2;
        regs[2] = 32'd4;
        regs[3] = 32'd8;
        run_dump(0, 3, 0, 1'b0, 1'b0, "csum");
        run_dump(0, 3, 2, 1'b1, 1'b0, "csum_bp");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug read-out engine that acts as the initiator on the register file read interface.
- On a start pulse it requests a CPU stall and waits for acknowledge. It then walks a register index range through its own read address port, captures each combinational read value, and streams it out over a valid/ready channel.
- Sits beside the register file, on a dedicated read port or a muxed second read port, and feeds the debug/host link.

Parameters:
- WIDTH, 32, data word width (matches `WIDTH)
- R_WIDTH, 5, register index width (matches `R_WIDTH)
- REGSIZE, 32, number of registers (matches `REGSIZE); last index REGSIZE-1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- first_reg  in  R_WIDTH  first index, latched on accepted start
- last_reg  in  R_WIDTH  last index inclusive, latched on accepted start
- stall_req  out  1  asks the CPU to freeze regwrite
- stall_ack  in  1  CPU frozen
- rd_reg  out  R_WIDTH  register file read address
- rd_data  in  WIDTH  register file read data, combinational from rd_reg
- out_valid  out  1  stream data valid
- out_ready  in  1  sink accepts
- out_data  out  WIDTH  captured register value
- out_idx  out  R_WIDTH  index of out_data
- out_last  out  1  final beat of the dump
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at end of dump
- range_err  out  1  sticky until next accepted start; set when first_reg>last_reg or last_reg>REGSIZE-1

Behaviour:
- Reset, asynchronous active-low: state IDLE; every output 0, including rd_reg, out_data and out_idx.
- Reset asserted mid-dump aborts immediately. No done pulse; stall_req drops asynchronously.
- IDLE:
  - start=1 latches the range and clears range_err.
  - If the range is invalid: set range_err, pulse done next cycle, stay in IDLE. No stall_req and no beats.
  - Otherwise go to HALT with stall_req=1.
  - start is ignored in every other state.
- HALT: hold stall_req=1. When stall_ack=1, set idx=first_reg and go to READ. Wait indefinitely for the acknowledge.
- READ, one cycle: rd_reg=idx. At the clock edge capture out_data<=rd_data and out_idx<=idx, then go to SEND with out_valid=1.
- SEND:
  - out_data, out_idx and out_last stay stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: if idx==last, go to FIN; else idx<=idx+1 and go to READ.
  - out_last=1 only when idx==last.
- FIN: drop stall_req, pulse done for one cycle, return to IDLE.
- stall_req stays high from HALT through FIN. If stall_ack deasserts during READ or SEND, no special handling is required; the CPU owns that contract.
- Throughput: one beat per 2 cycles with out_ready held at 1.
- Latency: start to first out_valid = 2 + cycles until stall_ack.
- rd_reg holds its last value outside READ; the register file tolerates idle reads.
- No wrap-around: the incrementer never passes last_reg. Index REGSIZE-1 as last is legal.

Optional Feature:
- Macro REGDUMP_CHECKSUM_EN.
- Defined:
  - After the last register beat, emit one extra beat with out_data = XOR of all dumped words and out_idx = all-ones.
  - out_last moves to this checksum beat; adds CSUM state between SEND and FIN.
  - The accumulator clears on accepted start.
- Undefined: no extra beat, no accumulator.

Decomposition:
- Shared defines header holds WIDTH/R_WIDTH/REGSIZE and the state encodings (IDLE, HALT, READ, SEND, CSUM, FIN) as named constants.
- Single module. No sub-module is warranted; the checksum accumulator is a few lines inside the ifdef.

Test Plan:
- Preload r0..r31 = 32'h1000_0000+i; start with first=0, last=31; out_ready=1; stall_ack 3 cycles after stall_req -> 32 beats with idx 0..31, data 32'h1000_0000..32'h1000_001F, out_last only on idx 31, done 1 cycle after the last handshake, stall_req low after that.
- first=5, last=5 -> exactly one beat: idx 5, out_last=1, done pulse, busy low 1 cycle later.
- first=9, last=4 -> range_err=1, done pulse, stall_req never asserted, no out_valid.
- out_ready toggled pseudo-randomly for range 2..6 -> data, idx and last held stable during backpressure; 5 beats in order, none lost or duplicated.
- rst_n pulsed low while in SEND at idx 12 -> all outputs 0 immediately, no done; a subsequent start runs a clean dump.
- With REGDUMP_CHECKSUM_EN, range 0..3, values 1,2,4,8 -> 5th beat out_data=15, out_idx=31 (all-ones), out_last on the 5th beat only.
